// File: rtl/audio_sfx_scheduler_if.sv
// Requester, sample-ROM and I2S-transmitter signals of the sound-effect scheduler.
// Directions are named from the scheduler's side (i_ into it, o_ out of it).
`timescale 1ns/1ps
interface audio_sfx_scheduler_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 4,
  parameter int ADDR_W  = 12,
  parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
  logic [NUM_SRC-1:0]        i_trigger;
  logic [NUM_SRC*ADDR_W-1:0] i_src_base;
  logic [NUM_SRC*ADDR_W-1:0] i_src_len;
  logic                      i_ready;
  logic [WIDTH-1:0]          i_rom_data;
  logic [ADDR_W-1:0]         o_rom_addr;
  logic                      o_rom_rd;
  logic [2*WIDTH-1:0]        o_tx;
  logic                      o_on_off;
  logic [SRC_W-1:0]          o_active_src;
  logic [NUM_SRC-1:0]        o_sfx_done;

  modport slave (
    input  i_trigger, i_src_base, i_src_len, i_ready, i_rom_data,
    output o_rom_addr, o_rom_rd, o_tx, o_on_off, o_active_src, o_sfx_done
  );

  modport master (
    output i_trigger, i_src_base, i_src_len, i_ready, i_rom_data,
    input  o_rom_addr, o_rom_rd, o_tx, o_on_off, o_active_src, o_sfx_done
  );
endinterface

// File: rtl/audio_sfx_scheduler.sv
// Plays one sound effect at a time from a sample ROM into the I2S frame word,
// lowest requester index wins and pre-empts; all logic runs on the falling clock edge.
//
// state   | meaning
// IDLE    | nothing playing; loads the zero word on frame boundaries, starts lowest pending
// ISSUE   | one-cycle ROM read of base+offset for the active source
// CAPTURE | ROM data valid; latch it as the next sample and advance offset
// HOLD    | sample waiting for the next frame boundary
`timescale 1ns/1ps
module audio_sfx_scheduler #(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 4,
  parameter int ADDR_W  = 12
) (
  input logic                  clk,
  input logic                  rst_n,
  audio_sfx_scheduler_if.slave bus
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_HOLD} state_t;

  state_t               r_state, w_state_nxt;
  logic [SRC_W-1:0]     r_src, w_src_nxt;
  logic [ADDR_W-1:0]    r_offset, w_offset_nxt;
  logic [NUM_SRC-1:0]   r_pending, w_pending_nxt;
  logic [WIDTH-1:0]     r_next_sample, w_next_sample_nxt;
  logic [2*WIDTH-1:0]   r_tx, w_tx_nxt;
  logic                 r_on_off, w_on_off_nxt;
  logic [NUM_SRC-1:0]   r_done, w_done_nxt;
  logic                 r_ready_q;

  logic                 w_ready_rise;
  logic [NUM_SRC-1:0]   w_trig_v;
  logic [NUM_SRC-1:0]   w_pend_eff;
  logic [SRC_W-1:0]     w_tlow, w_plow;
  logic                 w_preempt;
  logic [ADDR_W-1:0]    w_base, w_len;

  function automatic logic [SRC_W-1:0] f_lowest(input logic [NUM_SRC-1:0] vec);
    f_lowest = '0;
    for (int i = NUM_SRC-1; i >= 0; i--)
      if (vec[i]) f_lowest = SRC_W'(i);
  endfunction

  // A zero-length request is dropped before it can become pending.
  always_comb begin
    w_trig_v = '0;
    for (int i = 0; i < NUM_SRC; i++)
      w_trig_v[i] = bus.i_trigger[i] && (bus.i_src_len[i*ADDR_W +: ADDR_W] != '0);
  end

  assign w_ready_rise = bus.i_ready && !r_ready_q;
  assign w_pend_eff   = r_pending | w_trig_v;
  assign w_tlow       = f_lowest(w_trig_v);
  assign w_plow       = f_lowest(w_pend_eff);
  assign w_base       = bus.i_src_base[int'(r_src)*ADDR_W +: ADDR_W];
  assign w_len        = bus.i_src_len[int'(r_src)*ADDR_W +: ADDR_W];
  // Equal index is a restart of the active source; lower index pre-empts it.
  assign w_preempt    = (r_state != S_IDLE) && (w_trig_v != '0) && (w_tlow <= r_src);

  always_comb begin
    w_state_nxt       = r_state;
    w_src_nxt         = r_src;
    w_offset_nxt      = r_offset;
    w_pending_nxt     = r_pending | w_trig_v;
    w_next_sample_nxt = r_next_sample;
    w_tx_nxt          = r_tx;
    w_done_nxt        = '0;
    case (r_state)
      S_IDLE: begin
        if (w_ready_rise) w_tx_nxt = '0;
        if (w_pend_eff != '0) begin
          w_src_nxt              = w_plow;
          w_offset_nxt           = '0;
          w_pending_nxt[w_plow]  = 1'b0;
          w_state_nxt            = S_ISSUE;
        end
      end
      S_ISSUE:   w_state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        w_next_sample_nxt = bus.i_rom_data;
        w_offset_nxt      = r_offset + ADDR_W'(1);
        w_state_nxt       = S_HOLD;
      end
      S_HOLD: begin
        if (w_ready_rise) begin
          w_tx_nxt = {r_next_sample, r_next_sample};
          if (r_offset == w_len) begin
            w_done_nxt[r_src] = 1'b1;
            w_state_nxt       = S_IDLE;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Pre-emption overrides everything: in-flight read and held sample are dropped, Tx untouched.
    if (w_preempt) begin
      w_src_nxt             = w_tlow;
      w_offset_nxt          = '0;
      w_pending_nxt[w_tlow] = 1'b0;
      w_next_sample_nxt     = r_next_sample;
      w_tx_nxt              = r_tx;
      w_done_nxt            = '0;
      w_state_nxt           = S_ISSUE;
    end
  end

  // onOff drops on the frame boundary that loads the trailing zero word.
  always_comb begin
    w_on_off_nxt = r_on_off;
    if ((r_state != S_IDLE) || (w_pend_eff != '0)) w_on_off_nxt = 1'b1;
    else if (w_ready_rise)                          w_on_off_nxt = 1'b0;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_src         <= '0;
      r_offset      <= '0;
      r_pending     <= '0;
      r_next_sample <= '0;
      r_tx          <= '0;
      r_on_off      <= 1'b0;
      r_done        <= '0;
      r_ready_q     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_src         <= w_src_nxt;
      r_offset      <= w_offset_nxt;
      r_pending     <= w_pending_nxt;
      r_next_sample <= w_next_sample_nxt;
      r_tx          <= w_tx_nxt;
      r_on_off      <= w_on_off_nxt;
      r_done        <= w_done_nxt;
      r_ready_q     <= bus.i_ready;
    end
  end

  assign bus.o_rom_rd     = (r_state == S_ISSUE);
  assign bus.o_rom_addr   = (r_state == S_ISSUE) ? (w_base + r_offset) : '0;
  assign bus.o_tx         = r_tx;
  assign bus.o_on_off     = r_on_off;
  assign bus.o_active_src = (r_state == S_IDLE) ? '0 : r_src;
  assign bus.o_sfx_done   = r_done;
endmodule

// File: tb/tb_audio_sfx_scheduler.sv
// Bench for audio_sfx_scheduler: random triggers and frame timing against a
// sample-stream model, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_audio_sfx_scheduler;
  typedef logic [11:0] aq_t[$];
  typedef logic [31:0] wq_t[$];
  typedef int          iq_t[$];

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  audio_sfx_scheduler_if bus ();
  audio_sfx_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [11:0] cfg_base[4];
  logic [11:0] cfg_len[4];
  logic [3:0]  tag;
  int          n_vec = 0;
  int          n_err = 0;

  always_comb begin
    bus.i_src_base = '0;
    bus.i_src_len  = '0;
    for (int i = 0; i < 4; i++) begin
      bus.i_src_base[i*12 +: 12] = cfg_base[i];
      bus.i_src_len[i*12 +: 12]  = cfg_len[i];
    end
  end

  function automatic logic [15:0] rom_f(input logic [11:0] a);
    return {tag, a};
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ROM: read strobe seen in one cycle, data presented during the next.
  logic        rd_pend = 1'b0;
  logic [11:0] rd_addr = '0;
  always @(posedge clk) begin
    bus.i_rom_data = rd_pend ? rom_f(rd_addr) : 16'hDEAD;
    rd_pend = bus.o_rom_rd;
    rd_addr = bus.o_rom_addr;
  end

  // Transmitter frame clock with a randomly varying period.
  initial begin
    bus.i_ready = 1'b0;
    forever begin
      repeat ($urandom_range(3, 7)) @(posedge clk);
      #1 bus.i_ready = ~bus.i_ready;
    end
  end

  // Behavioural model: which source owns the bus, how many samples it has fetched,
  // how far the current fetch has progressed, and what word the frame carries.
  bit [3:0]    m_pend;
  bit          m_busy;
  int          m_src, m_pos, m_age;
  logic [15:0] m_sample;
  logic [31:0] m_tx;
  bit          m_on;
  logic [3:0]  m_done;
  bit          m_ready_prev;

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_busy = 0; m_src = 0; m_pos = 0; m_age = 0;
    m_sample = '0; m_tx = '0; m_on = 0; m_done = '0; m_ready_prev = 0;
  endtask

  task automatic m_start(input int s);
    m_src = s; m_pos = 0; m_age = 0; m_busy = 1;
  endtask

  task automatic model_edge();
    logic [3:0] tv;
    bit rise, old_busy, any_eff;
    int tlow, plow;
    rise = bus.i_ready && !m_ready_prev;
    m_ready_prev = bus.i_ready;
    tv = '0;
    for (int i = 0; i < 4; i++) if (bus.i_trigger[i] && cfg_len[i] != 0) tv[i] = 1'b1;
    old_busy = m_busy;
    any_eff  = ((m_pend | tv) != 0);
    m_done   = '0;
    tlow     = lowest(tv);
    m_pend   = m_pend | tv;
    if (m_busy && tlow >= 0 && tlow <= m_src) begin
      m_pend[tlow] = 1'b0;
      m_start(tlow);
    end else if (!m_busy) begin
      if (rise) m_tx = '0;
      plow = lowest(m_pend);
      if (plow >= 0) begin
        m_pend[plow] = 1'b0;
        m_start(plow);
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (m_age == 1) begin
      m_sample = rom_f(cfg_base[m_src] + 12'(m_pos));
      m_pos++;
      m_age = 2;
    end else if (rise) begin
      m_tx = {m_sample, m_sample};
      if (m_pos == int'(cfg_len[m_src])) begin
        m_done[m_src] = 1'b1;
        m_busy = 0;
      end else begin
        m_age = 0;
      end
    end
    if (old_busy || any_eff) m_on = 1;
    else if (rise)           m_on = 0;
  endtask

  initial model_reset();
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    else        model_edge();
  end

  always @(posedge clk) begin
    logic exp_rd;
    exp_rd = m_busy && (m_age == 0);
    chk("tx", bus.o_tx, m_tx);
    chk("on_off", 32'(bus.o_on_off), 32'(m_on));
    chk("rom_rd", 32'(bus.o_rom_rd), 32'(exp_rd));
    if (exp_rd) chk("rom_addr", 32'(bus.o_rom_addr), 32'(12'(cfg_base[m_src] + 12'(m_pos))));
    chk("active_src", 32'(bus.o_active_src), m_busy ? 32'(m_src) : 32'd0);
    chk("sfx_done", 32'(bus.o_sfx_done), 32'(m_done));
  end

  // Observation queues used by the directed scenarios.
  aq_t         q_addr;
  iq_t         q_src;
  wq_t         q_tx;
  iq_t         q_done;
  int          done_cnt[4];
  bit          seen_on;
  logic [31:0] last_tx = '0;
  always @(posedge clk) begin
    if (bus.o_rom_rd) begin
      q_addr.push_back(bus.o_rom_addr);
      q_src.push_back(int'(bus.o_active_src));
    end
    if (bus.o_tx !== last_tx) q_tx.push_back(bus.o_tx);
    last_tx = bus.o_tx;
    for (int i = 0; i < 4; i++)
      if (bus.o_sfx_done[i]) begin done_cnt[i]++; q_done.push_back(i); end
    if (bus.o_on_off) seen_on = 1;
  end

  task automatic clear_mon();
    q_addr.delete(); q_src.delete(); q_tx.delete(); q_done.delete();
    for (int i = 0; i < 4; i++) done_cnt[i] = 0;
    seen_on = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    bus.i_trigger = '0;
    for (int i = 0; i < 4; i++) begin cfg_base[i] = '0; cfg_len[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int snap_addr, snap_tx;
  task automatic pulse_trigger(input logic [3:0] t, input bit check_lat);
    @(posedge clk);
    #1;
    snap_addr = q_addr.size();
    snap_tx   = q_tx.size();
    bus.i_trigger = t;
    @(posedge clk);
    if (check_lat) chk("first_rom_rd_latency", 32'(bus.o_rom_rd), 32'd1);
    #1 bus.i_trigger = '0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (!m_busy && m_pend == 0 && !bus.o_on_off) begin ok = 1; break; end
    end
    #1;
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic chk_addrs(input string nm, input aq_t exp);
    chk({nm, "_count"}, 32'(q_addr.size()), 32'(exp.size()));
    foreach (exp[i]) if (i < q_addr.size()) chk(nm, 32'(q_addr[i]), 32'(exp[i]));
  endtask

  initial begin
    aq_t ea;
    wq_t et;
    bit  ok;
    rst_n = 1'b0;
    bus.i_trigger = '0;
    tag = 4'h0;
    for (int i = 0; i < 4; i++) begin cfg_base[i] = '0; cfg_len[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tx", bus.o_tx, 32'd0);
    chk("reset_on_off", 32'(bus.o_on_off), 32'd0);
    chk("reset_rom_rd", 32'(bus.o_rom_rd), 32'd0);
    chk("reset_rom_addr", 32'(bus.o_rom_addr), 32'd0);

    // Single play of src1: three samples then the zero word.
    do_reset();
    tag = 4'h0; cfg_base[1] = 12'h100; cfg_len[1] = 12'd3;
    clear_mon();
    pulse_trigger(4'b0010, 1);
    wait_idle();
    ea = '{12'h100, 12'h101, 12'h102};
    chk_addrs("single_addr", ea);
    et = '{32'h01000100, 32'h01010101, 32'h01020102, 32'h00000000};
    chk("single_tx_count", 32'(q_tx.size()), 32'(et.size()));
    foreach (et[i]) if (i < q_tx.size()) chk("single_tx", q_tx[i], et[i]);
    chk("single_done1", 32'(done_cnt[1]), 32'd1);

    // Simultaneous src0 and src2: lower index first.
    do_reset();
    tag = 4'h1; cfg_base[0] = 12'h200; cfg_len[0] = 12'd2; cfg_base[2] = 12'h300; cfg_len[2] = 12'd2;
    clear_mon();
    pulse_trigger(4'b0101, 1);
    wait_idle();
    ea = '{12'h200, 12'h201, 12'h300, 12'h301};
    chk_addrs("simul_addr", ea);
    chk("simul_src_count", 32'(q_src.size()), 32'd4);
    if (q_src.size() == 4) begin
      chk("simul_src_first", 32'(q_src[0]), 32'd0);
      chk("simul_src_last", 32'(q_src[3]), 32'd2);
    end
    chk("simul_done_count", 32'(q_done.size()), 32'd2);
    if (q_done.size() == 2) chk("simul_done_order", 32'(q_done[0] * 4 + q_done[1]), 32'd2);

    // Pre-emption of src3 mid-play by src1.
    do_reset();
    tag = 4'h2; cfg_base[3] = 12'h400; cfg_len[3] = 12'd10; cfg_base[1] = 12'h050; cfg_len[1] = 12'd2;
    clear_mon();
    pulse_trigger(4'b1000, 1);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (q_addr.size() >= 5) begin ok = 1; break; end
    end
    chk("preempt_reach_offset5", 32'(ok), 32'd1);
    repeat (2) @(posedge clk);
    pulse_trigger(4'b0010, 0);
    wait_idle();
    chk("preempt_reads_after", 32'(q_addr.size() - snap_addr), 32'd2);
    if (q_addr.size() > snap_addr) chk("preempt_first_addr", 32'(q_addr[snap_addr]), 32'h050);
    if (q_tx.size() > snap_tx) chk("preempt_next_tx", q_tx[snap_tx], 32'h20502050);
    else chk("preempt_next_tx_seen", 32'(q_tx.size()), 32'(snap_tx + 1));
    chk("preempt_no_done3", 32'(done_cnt[3]), 32'd0);
    chk("preempt_done1", 32'(done_cnt[1]), 32'd1);

    // Zero-length request is ignored.
    do_reset();
    cfg_base[2] = 12'h123; cfg_len[2] = 12'd0;
    clear_mon();
    pulse_trigger(4'b0100, 0);
    repeat (30) @(posedge clk);
    #1;
    chk("len0_no_rom_rd", 32'(q_addr.size()), 32'd0);
    chk("len0_on_never", 32'(seen_on), 32'd0);
    chk("len0_tx_zero", bus.o_tx, 32'd0);

    // Address wrap past the top of the ROM.
    do_reset();
    tag = 4'h3; cfg_base[0] = 12'hFFE; cfg_len[0] = 12'd4;
    clear_mon();
    pulse_trigger(4'b0001, 1);
    wait_idle();
    ea = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    chk_addrs("wrap_addr", ea);

    // Reset during a read after the first sample has gone out.
    do_reset();
    tag = 4'h5; cfg_base[1] = 12'h100; cfg_len[1] = 12'd3;
    clear_mon();
    pulse_trigger(4'b0010, 1);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (q_tx.size() >= 1 && bus.o_rom_rd) begin ok = 1; break; end
    end
    chk("rst_mid_reach_issue", 32'(ok), 32'd1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_tx", bus.o_tx, 32'd0);
    chk("rst_mid_on_off", 32'(bus.o_on_off), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    snap_addr = q_addr.size();
    repeat (40) @(posedge clk);
    #1;
    chk("rst_mid_no_done", 32'(done_cnt[1]), 32'd0);
    chk("rst_mid_idle_reads", 32'(q_addr.size()), 32'(snap_addr));
    chk("rst_mid_idle_on", 32'(bus.o_on_off), 32'd0);

    // Randomized phases checked every cycle against the model.
    for (int ph = 0; ph < 3; ph++) begin
      do_reset();
      tag = 4'(ph + 8);
      for (int i = 0; i < 4; i++) begin
        cfg_base[i] = (ph == 1 && i == 3) ? 12'hFFD : 12'($urandom_range(0, 4095));
        cfg_len[i]  = ($urandom_range(0, 4) == 0) ? 12'd0 : 12'($urandom_range(1, 8));
      end
      for (int c = 0; c < 3000; c++) begin
        @(posedge clk);
        #1;
        if ($urandom_range(0, 24) == 0) bus.i_trigger = 4'($urandom_range(1, 15));
        else                            bus.i_trigger = '0;
      end
      @(posedge clk);
      #1 bus.i_trigger = '0;
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end
endmodule
